// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding and load-use hazard controller for a 5-stage pipeline.
//   A shadow pipeline tracks the producers now in EX and MEM. When an
//   instruction leaves ID, its operand-forwarding selects are computed and
//   registered, so they are stable for the whole EX cycle of that instruction.
//   A load in EX whose destination is read by the ID instruction produces a
//   one-cycle stall. A flush kills the ID instruction and takes priority over
//   the stall.
//
//   Select encoding: 00 = register file, 01 = WB result, 10 = MEM ALU result.
//
//   Optional feature: define FWD_STALL_CNT_EN to add the saturating
//   load-use stall counter and its stall_count output port.
//
// Ports
//   clk          : pipeline clock, rising edge
//   reset        : synchronous, active-high reset
//   id_valid     : ID stage holds a real instruction
//   id_rs1/rs2   : source register indices of the ID instruction
//   id_use_rs1/2 : ID instruction actually reads rs1/rs2
//   id_rd        : destination register index of the ID instruction
//   id_reg_write : ID instruction writes rd
//   id_mem_read  : ID instruction is a load
//   flush        : taken branch/jump resolved in EX; kill the ID instruction
//   stall        : hold PC and IF/ID (combinational)
//   fwd_a/fwd_b  : registered operand selects for the instruction in EX
//   stall_count  : load-use stall cycles (FWD_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_count
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // A slot supplies a value for source rs only if it really writes a
  // non-zero register equal to rs and the source is actually read.
  function automatic logic hit(input logic                  v,
                               input logic                  wr,
                               input logic [REG_ADDR_W-1:0] rd,
                               input logic [REG_ADDR_W-1:0] rs,
                               input logic                  use_rs);
    return use_rs && v && wr && (rd != '0) && (rd == rs);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Only the EX and MEM producers steer forwarding decisions: a producer in
  // MEM at issue time is in WB during the consumer's EX cycle, which is what
  // select 01 means. The WB slot and the consumer's source fields therefore
  // never influence an output and are not stored.
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;

  logic load_use;
  logic issue;

  always_comb begin
    load_use = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
               ((id_use_rs1 && (ex_rd_q == id_rs1)) ||
                (id_use_rs2 && (ex_rd_q == id_rs2)));
    // A killed instruction never stalls.
    stall    = load_use && !flush;
    issue    = id_valid && !flush && !load_use;

    mem_valid_d     = ex_valid_q;
    mem_rd_d        = ex_rd_q;
    mem_reg_write_d = ex_reg_write_q;

    // Data fields are captured every cycle; ex_valid_d alone marks a bubble.
    ex_valid_d     = issue;
    ex_rd_d        = id_rd;
    ex_reg_write_d = id_reg_write;
    ex_mem_read_d  = id_mem_read;

    // The EX producer is newer than the MEM producer, so it is tested first.
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    if (issue) begin
      if (hit(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs1, id_use_rs1))
        fwd_a_d = SEL_MEM;
      else if (hit(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs1, id_use_rs1))
        fwd_a_d = SEL_WB;
      if (hit(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs2, id_use_rs2))
        fwd_b_d = SEL_MEM;
      else if (hit(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs2, id_use_rs2))
        fwd_b_d = SEL_WB;
    end
  end

  // ID -> EX / EX -> MEM boundary: control state
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      fwd_a_q     <= SEL_RF;
      fwd_b_q     <= SEL_RF;
    end else begin
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
    end
  end

  // ID -> EX / EX -> MEM boundary: slot data, qualified by the valid bits
  always_ff @(posedge clk) begin
    ex_rd_q         <= ex_rd_d;
    ex_reg_write_q  <= ex_reg_write_d;
    ex_mem_read_q   <= ex_mem_read_d;
    mem_rd_q        <= mem_rd_d;
    mem_reg_write_q <= mem_reg_write_d;
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule
